// File: rtl/regfile_writeback.sv
// regfile_writeback: in-order write-back queue owning the register-file write port.
// Two producers (A: single-cycle path with priority, B: multi-cycle unit) push
// into a small FIFO that drains one entry per cycle onto rf_we/rf_addr/rf_data.
// Pending-write lookup for two source addresses lets decode stall or bypass.
// Optional feature macro: WB_BYPASS_EN builds q_data0/q_data1 and the
// youngest-match data mux.
module regfile_writeback #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         a_valid,
    input  logic [4:0]                   a_addr,
    input  logic [W-1:0]                 a_data,
    output logic                         a_ready,
    input  logic                         b_valid,
    input  logic [4:0]                   b_addr,
    input  logic [W-1:0]                 b_data,
    output logic                         b_ready,
    output logic                         rf_we,
    output logic [4:0]                   rf_addr,
    output logic [W-1:0]                 rf_data,
    input  logic [4:0]                   q_addr0,
    input  logic [4:0]                   q_addr1,
    output logic                         q_pend0,
    output logic                         q_pend1,
`ifdef WB_BYPASS_EN
    output logic [W-1:0]                 q_data0,
    output logic [W-1:0]                 q_data1,
`endif
    output logic [$clog2(DEPTH):0]       count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [4:0]    fifo_addr [DEPTH];
    logic [W-1:0]  fifo_data [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] b_slot;
    logic          push_a;
    logic          push_b;
    logic          pop;

    // Ready is judged on the registered count only; a same-cycle drain is not credited.
    assign a_ready = count < CW'(DEPTH);
    assign b_ready = (count + CW'(a_valid && (a_addr != 5'd0))) < CW'(DEPTH);

    // Writes to r0 handshake normally but never enter the queue.
    assign push_a = a_valid && a_ready && (a_addr != 5'd0);
    assign push_b = b_valid && b_ready && (b_addr != 5'd0);
    assign pop    = (count != '0);
    assign b_slot = wr_ptr + PW'(push_a);

    // Queue storage: A lands at the tail, B behind it when both push together.
    always_ff @(posedge clk) begin
        if (push_a) begin
            fifo_addr[wr_ptr] <= a_addr;
            fifo_data[wr_ptr] <= a_data;
        end
        if (push_b) begin
            fifo_addr[b_slot] <= b_addr;
            fifo_data[b_slot] <= b_data;
        end
    end

    // Pointers, occupancy and the registered register-file drive stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rf_we   <= 1'b0;
            rf_addr <= '0;
            rf_data <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push_a) + PW'(push_b);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + CW'(push_a) + CW'(push_b) - CW'(pop);
            rf_we  <= pop;
            if (pop) begin
                rf_addr <= fifo_addr[rd_ptr];
                rf_data <= fifo_data[rd_ptr];
            end
        end
    end

    logic [4:0]   q_addr [2];
    logic [1:0]   pend;
`ifdef WB_BYPASS_EN
    logic [W-1:0] qdata [2];
`endif

    assign q_addr[0] = q_addr0;
    assign q_addr[1] = q_addr1;

    // Lookup: rf stage is oldest, then FIFO head to tail, so the last match is the youngest.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0;
`ifdef WB_BYPASS_EN
            qdata[p] = '0;
`endif
            if (q_addr[p] != 5'd0) begin
                if (rf_we && (rf_addr == q_addr[p])) begin
                    pend[p] = 1'b1;
`ifdef WB_BYPASS_EN
                    qdata[p] = rf_data;
`endif
                end
                for (int i = 0; i < int'(DEPTH); i++) begin
                    if ((CW'(i) < count) && (fifo_addr[rd_ptr + PW'(i)] == q_addr[p])) begin
                        pend[p] = 1'b1;
`ifdef WB_BYPASS_EN
                        qdata[p] = fifo_data[rd_ptr + PW'(i)];
`endif
                    end
                end
            end
        end
    end

    assign q_pend0 = pend[0];
    assign q_pend1 = pend[1];
`ifdef WB_BYPASS_EN
    assign q_data0 = qdata[0];
    assign q_data1 = qdata[1];
`endif

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-back queue that owns the single write port of the 32×32 MIPS register file. It accepts register writes from two producers: port A, the single-cycle ALU/load path, and port B, a multi-cycle unit such as mult/div or a late load. It buffers the writes in order in a small FIFO and drains one per cycle into `regWrite`/`addrDestination`/`writeData`. It also reports, for two source addresses, whether a younger value is still pending, so decode can stall or bypass.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries, a power of two, at least 2.
- `W`, default 32: data width.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `a_valid` in 1, `a_addr` in 5, `a_data` in W: write request from port A.
- `a_ready` out 1: port A request is accepted this cycle.
- `b_valid` in 1, `b_addr` in 5, `b_data` in W: write request from port B.
- `b_ready` out 1: port B request is accepted this cycle.
- `rf_we` out 1, `rf_addr` out 5, `rf_data` out W: registered drive to the register-file write port.
- `q_addr0`, `q_addr1` in 5: lookup addresses, normally rs and rt.
- `q_pend0`, `q_pend1` out 1: a write to the looked-up address is queued or in flight.
- `q_data0`, `q_data1` out W: the youngest pending value for that address. Present only with `WB_BYPASS_EN`.
- `count` out clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- Handshake: a transfer occurs on a rising edge where `valid && ready` are both high. The producer holds `addr`/`data` stable while `valid && !ready`.
- Writes to address 0 are accepted with `ready` asserted but are discarded. They never enter the FIFO, never drive `rf_we`, and never set `pend`.
- Ready rules, combinational from the registered `count` (the slot freed by a same-cycle drain is not credited):
  - `a_ready = count < DEPTH`.
  - `b_ready = (count + (a_valid && a_addr != 0)) < DEPTH`.
- Ordering:
  - Port A has fixed priority.
  - When both ports transfer on the same edge, A's entry is enqueued older than B's.
  - The FIFO drains strictly in order.
- Drain, at each edge:
  - If `count > 0` before the edge: `rf_we <= 1`, `rf_addr`/`rf_data <=` head entry, and the head is popped.
  - Otherwise `rf_we <= 0`; `rf_addr`/`rf_data` hold their values.
- Count update per edge: `count_next = count + pushes - (count > 0)`. Pushes are 0, 1 or 2.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
- Lookup, combinational over all valid FIFO entries plus the `rf_*` stage when `rf_we = 1`:
  - `pend` = any match.
  - `data` = youngest match, with priority FIFO tail → head → `rf_*` stage.
  - `q_addr = 0` gives `pend = 0` and `data = 0`.
  - A request being presented this cycle but not yet clocked is not visible to the lookup.
- Reset:
  - Asynchronously clears pointers and count, and sets `rf_we = 0`, `rf_addr = 0`, `rf_data = 0`.
  - Hence `a_ready = b_ready = 1` during and after reset, and `pend = 0`.
  - A reset mid-operation discards all queued writes. No partial write reaches `rf_*`.

## Timing
- Accept-to-register-file latency with an empty FIFO:
  - Request accepted at edge N.
  - `rf_we = 1` with that entry after edge N+1.
  - The register file captures it at edge N+2.
- `pend` rises in the cycle after edge N and stays high until the cycle after the register file captures the last matching write.
- Throughput: one drain per cycle. Peak enqueue is 2 per cycle, so sustained dual-port traffic fills the FIFO and deasserts B first.
- Full, with `count = DEPTH`: both ready outputs are low even though a drain happens the same edge; they rise the next cycle.
- Empty: `rf_we` drops to 0 one cycle after the last pop.

## Configuration
- `WB_BYPASS_EN` defined:
  - The `q_data0`/`q_data1` ports and the youngest-match data mux are built.
  - Decode may forward the pending value instead of stalling.
- `WB_BYPASS_EN` undefined:
  - The data ports and mux are removed.
  - Only `q_pend0`/`q_pend1` exist, and decode must stall while `pend = 1`.
  - All other behaviour is identical.

## Test plan
- Reset, then A writes addr 5, data 0xDEADBEEF at edge 1:
  - `rf_we = 1`, `rf_addr = 5`, `rf_data = 0xDEADBEEF` after edge 2.
  - `q_pend0 = 1` for `q_addr0 = 5` after edges 1–2, then 0 after edge 3.
- Same-edge A (addr 3, 0x11) and B (addr 3, 0x22):
  - Drain order is 0x11 then 0x22.
  - `q_data0` for addr 3 reads 0x22 while both are pending and 0x22 with only the `rf_*` stage left.
- Fill to `DEPTH = 4` with A and B both valid:
  - `b_ready = 0` at `count = 3` with `a_valid = 1`.
  - Both ready outputs are 0 at `count = 4`; `a_ready` returns to 1 the cycle after one drain.
  - Pointer wrap is exercised over 12 consecutive writes, all draining in order.
- A writes to addr 0 with data 0xFFFFFFFF:
  - Accepted with `a_ready = 1`.
  - `count` is unchanged, `rf_we` stays 0, and `q_pend` for addr 0 is 0.
- Assert `rst` asynchronously between edges while `count = 3` and `rf_we = 1`:
  - Immediately `rf_we = 0`, `count = 0`, all `pend = 0`.
  - No queued data appears after `rst` is released.
